// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port fixed-latency memory between
// instruction fetch (IF) and the data (MEM-stage) port.
// Ports: clk/rst; ifReq/ifAddr -> ifGnt/ifValid/ifData;
//   dReq/dWe/dAddr/dWrData -> dGnt/dValid/dRdData;
//   memReq/memWe/memAddr/memWrData -> memory, memRdData <- memory;
//   stall -> CPU pipeline hold request.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddr,
    output logic                  ifGnt,
    output logic                  ifValid,
    output logic [DATA_WIDTH-1:0] ifData,
    input  logic                  dReq,
    input  logic                  dWe,
    input  logic [ADDR_WIDTH-1:0] dAddr,
    input  logic [DATA_WIDTH-1:0] dWrData,
    output logic                  dGnt,
    output logic                  dValid,
    output logic [DATA_WIDTH-1:0] dRdData,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWrData,
    input  logic [DATA_WIDTH-1:0] memRdData,
    output logic                  stall
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] LAT  = 3'(MEM_LATENCY);
    localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] starve_q, starve_d;
    // owner of the access in flight: 1 = data port, 0 = IF
    logic       ownd_q, ownd_d;
    logic       we_q, we_d;

    logic done;
    logic slot;
    logic pick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            starve_q <= '0;
            ownd_q   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            ownd_q   <= ownd_d;
            we_q     <= we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        ownd_d    = ownd_q;
        we_d      = we_q;
        ifGnt     = 1'b0;
        ifValid   = 1'b0;
        ifData    = '0;
        dGnt      = 1'b0;
        dValid    = 1'b0;
        dRdData   = '0;
        memReq    = 1'b0;
        memWe     = 1'b0;
        memAddr   = '0;
        memWrData = '0;
        stall     = 1'b0;
        done      = (state_q == BUSY) && (cnt_q == LAT);
        slot      = (state_q == IDLE) || done;
        // IF only beats a waiting data request once it has been
        // passed over STARVE_LIMIT times in a row.
        pick_d    = dReq && (!ifReq || (starve_q != SLIM));

        // Outputs are held at zero for as long as reset is asserted,
        // even though requests may already be present.
        if (!rst) begin
            if (done) begin
                if (ownd_q) begin
                    dValid  = 1'b1;
                    dRdData = we_q ? '0 : memRdData;
                end else begin
                    ifValid = 1'b1;
                    ifData  = memRdData;
                end
            end

            if ((state_q == BUSY) && !done) begin
                cnt_d = cnt_q + 3'd1;
            end

            if (slot) begin
                if (pick_d) begin
                    dGnt      = 1'b1;
                    memReq    = 1'b1;
                    memWe     = dWe;
                    memAddr   = dAddr;
                    memWrData = dWe ? dWrData : '0;
                    ownd_d    = 1'b1;
                    we_d      = dWe;
                    cnt_d     = 3'd1;
                    state_d   = BUSY;
                    if (ifReq && (starve_q != SLIM)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (ifReq) begin
                    ifGnt    = 1'b1;
                    memReq   = 1'b1;
                    memAddr  = ifAddr;
                    ownd_d   = 1'b0;
                    we_d     = 1'b0;
                    cnt_d    = 3'd1;
                    state_d  = BUSY;
                    starve_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            stall = (ifReq && !ifGnt) || (dReq && !dGnt) ||
                    ((state_q == BUSY) && !done);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a timestamp-based transaction model.
module tb_mem_port_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifReq;
    logic [AW-1:0] ifAddr;
    logic          dReq;
    logic          dWe;
    logic [AW-1:0] dAddr;
    logic [DW-1:0] dWrData;
    logic [DW-1:0] memRdData;

    logic          ifGnt0, ifValid0, dGnt0, dValid0;
    logic          memReq0, memWe0, stall0;
    logic [DW-1:0] ifData0, dRdData0, memWrData0;
    logic [AW-1:0] memAddr0;

    logic          ifGnt1, ifValid1, dGnt1, dValid1;
    logic          memReq1, memWe1, stall1;
    logic [DW-1:0] ifData1, dRdData1, memWrData1;
    logic [AW-1:0] memAddr1;

    int checks = 0;
    int errors = 0;

    // flags: ifGnt ifValid dGnt dValid memReq memWe stall
    logic [6:0] f0, f1, sf;
    logic       sel;
    logic [AW-1:0] s_memAddr;
    logic [DW-1:0] s_memWrData, s_ifData, s_dRdData;

    assign f0 = {ifGnt0, ifValid0, dGnt0, dValid0, memReq0, memWe0, stall0};
    assign f1 = {ifGnt1, ifValid1, dGnt1, dValid1, memReq1, memWe1, stall1};
    assign sf          = sel ? f1 : f0;
    assign s_memAddr   = sel ? memAddr1 : memAddr0;
    assign s_memWrData = sel ? memWrData1 : memWrData0;
    assign s_ifData    = sel ? ifData1 : ifData0;
    assign s_dRdData   = sel ? dRdData1 : dRdData0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MEM_LATENCY(2), .STARVE_LIMIT(LIM)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddr(ifAddr),
        .ifGnt(ifGnt0), .ifValid(ifValid0), .ifData(ifData0),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWrData(dWrData),
        .dGnt(dGnt0), .dValid(dValid0), .dRdData(dRdData0),
        .memReq(memReq0), .memWe(memWe0), .memAddr(memAddr0),
        .memWrData(memWrData0), .memRdData(memRdData),
        .stall(stall0)
    );

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .MEM_LATENCY(1), .STARVE_LIMIT(LIM)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .ifReq(ifReq), .ifAddr(ifAddr),
        .ifGnt(ifGnt1), .ifValid(ifValid1), .ifData(ifData1),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWrData(dWrData),
        .dGnt(dGnt1), .dValid(dValid1), .dRdData(dRdData1),
        .memReq(memReq1), .memWe(memWe1), .memAddr(memAddr1),
        .memWrData(memWrData1), .memRdData(memRdData),
        .stall(stall1)
    );

    task automatic idle_inputs();
        ifReq     = 1'b0;
        ifAddr    = '0;
        dReq      = 1'b0;
        dWe       = 1'b0;
        dAddr     = '0;
        dWrData   = '0;
        memRdData = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        ifReq = 1'b1;
        dReq  = 1'b1;
        ifAddr = 16'h1111;
        dAddr  = 16'h2222;
        #1;
        checks++;
        if (f0 !== 7'b0 || memAddr0 !== '0) begin
            errors++;
            $display("FAIL reset_outputs flags=%b addr=%h need 0", f0, memAddr0);
        end
        checks++;
        if (f1 !== 7'b0 || memWrData1 !== '0) begin
            errors++;
            $display("FAIL reset_outputs_lat1 flags=%b need 0", f1);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (f0 !== 7'b0) begin
            errors++;
            $display("FAIL reset_release flags=%b need 0", f0);
        end
    endtask

    task automatic test_if_fetch();
        do_reset();
        @(negedge clk);
        ifReq  = 1'b1;
        ifAddr = 16'h0010;
        #1;
        checks++;
        if (f0 !== 7'b1000100 || memAddr0 !== 16'h0010) begin
            errors++;
            $display("FAIL fetch_t0 flags=%b addr=%h need 1000100 0010", f0, memAddr0);
        end
        @(negedge clk);
        ifReq = 1'b0;
        #1;
        checks++;
        if (f0 !== 7'b0000001 || memAddr0 !== '0) begin
            errors++;
            $display("FAIL fetch_t1 flags=%b addr=%h need 0000001 0", f0, memAddr0);
        end
        @(negedge clk);
        memRdData = 32'h0000_1234;
        #1;
        checks++;
        if (f0 !== 7'b0100000 || ifData0 !== 32'h1234) begin
            errors++;
            $display("FAIL fetch_t2 flags=%b data=%h need 0100000 1234", f0, ifData0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (f0 !== 7'b0 || ifData0 !== '0) begin
            errors++;
            $display("FAIL fetch_t3 flags=%b data=%h need 0", f0, ifData0);
        end
    endtask

    task automatic test_both();
        do_reset();
        @(negedge clk);
        ifReq  = 1'b1;
        ifAddr = 16'h0080;
        dReq   = 1'b1;
        dWe    = 1'b0;
        dAddr  = 16'h0040;
        #1;
        checks++;
        if (f0 !== 7'b0010101 || memAddr0 !== 16'h0040) begin
            errors++;
            $display("FAIL both_t0 flags=%b addr=%h need 0010101 0040", f0, memAddr0);
        end
        @(negedge clk);
        dReq = 1'b0;
        #1;
        checks++;
        if (f0 !== 7'b0000001) begin
            errors++;
            $display("FAIL both_t1 flags=%b need 0000001", f0);
        end
        @(negedge clk);
        memRdData = 32'hCAFE_0001;
        #1;
        checks++;
        if (f0 !== 7'b1001100 || dRdData0 !== 32'hCAFE_0001 ||
            memAddr0 !== 16'h0080) begin
            errors++;
            $display("FAIL both_t2 flags=%b rd=%h addr=%h need 1001100 cafe0001 0080",
                     f0, dRdData0, memAddr0);
        end
        @(negedge clk);
        ifReq = 1'b0;
        memRdData = 32'h0;
        #1;
        checks++;
        if (f0 !== 7'b0000001) begin
            errors++;
            $display("FAIL both_t3 flags=%b need 0000001", f0);
        end
        @(negedge clk);
        memRdData = 32'hCAFE_0002;
        #1;
        checks++;
        if (f0 !== 7'b0100000 || ifData0 !== 32'hCAFE_0002) begin
            errors++;
            $display("FAIL both_t4 flags=%b data=%h need 0100000 cafe0002", f0, ifData0);
        end
    endtask

    task automatic test_starve();
        logic [1:0] exp_g;
        do_reset();
        for (int t = 0; t <= 11; t++) begin
            @(negedge clk);
            ifReq  = 1'b1;
            ifAddr = 16'h0100;
            dReq   = 1'b1;
            dWe    = 1'b0;
            dAddr  = 16'h0200;
            #1;
            exp_g[1] = (t == 8);
            exp_g[0] = (t % 2 == 0) && (t != 8);
            checks++;
            if ({ifGnt0, dGnt0} !== exp_g) begin
                errors++;
                $display("FAIL starve_t%0d gnt(if,d)=%b need %b", t, {ifGnt0, dGnt0}, exp_g);
            end
        end
        idle_inputs();
    endtask

    task automatic test_store();
        do_reset();
        @(negedge clk);
        dReq    = 1'b1;
        dWe     = 1'b1;
        dAddr   = 16'h0020;
        dWrData = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (f0 !== 7'b0010110 || memWrData0 !== 32'hDEAD_BEEF ||
            memAddr0 !== 16'h0020) begin
            errors++;
            $display("FAIL store_t0 flags=%b wd=%h addr=%h need 0010110 deadbeef 0020",
                     f0, memWrData0, memAddr0);
        end
        @(negedge clk);
        dReq = 1'b0;
        #1;
        checks++;
        if (f0 !== 7'b0000001 || memWrData0 !== '0) begin
            errors++;
            $display("FAIL store_t1 flags=%b wd=%h need 0000001 0", f0, memWrData0);
        end
        @(negedge clk);
        memRdData = 32'h55AA_55AA;
        #1;
        checks++;
        if (f0 !== 7'b0001000 || dRdData0 !== '0) begin
            errors++;
            $display("FAIL store_t2 flags=%b rd=%h need 0001000 0", f0, dRdData0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        ifReq  = 1'b1;
        ifAddr = 16'h0030;
        #1;
        checks++;
        if (f0 !== 7'b1000100) begin
            errors++;
            $display("FAIL rstmid_t0 flags=%b need 1000100", f0);
        end
        @(negedge clk);
        ifReq = 1'b0;
        rst   = 1'b1;
        #1;
        checks++;
        if (f0 !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_t1 flags=%b need 0", f0);
        end
        @(negedge clk);
        rst       = 1'b0;
        memRdData = 32'h7777_7777;
        #1;
        checks++;
        if (f0 !== 7'b0 || ifData0 !== '0) begin
            errors++;
            $display("FAIL rstmid_t2 flags=%b data=%h need 0", f0, ifData0);
        end
        @(negedge clk);
        ifReq  = 1'b1;
        ifAddr = 16'h0044;
        #1;
        checks++;
        if (f0 !== 7'b1000100 || memAddr0 !== 16'h0044) begin
            errors++;
            $display("FAIL rstmid_t3 flags=%b addr=%h need 1000100 0044", f0, memAddr0);
        end
        @(negedge clk);
        ifReq = 1'b0;
        @(negedge clk);
        memRdData = 32'h0BAD_F00D;
        #1;
        checks++;
        if (f0 !== 7'b0100000 || ifData0 !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL rstmid_t5 flags=%b data=%h need 0100000 0badf00d", f0, ifData0);
        end
    endtask

    task automatic test_lat1();
        logic [6:0]    ef;
        logic [AW-1:0] ea;
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            idle_inputs();
            memRdData = 32'hA000_0000 + 32'(k);
            if (k < 8 && k % 2 == 0) begin
                ifReq  = 1'b1;
                ifAddr = 16'h0100 + 16'(k);
            end else if (k < 8) begin
                dReq  = 1'b1;
                dAddr = 16'h0200 + 16'(k);
            end
            #1;
            ef = '0;
            ef[6] = (k < 8) && (k % 2 == 0);
            ef[4] = (k < 8) && (k % 2 == 1);
            ef[2] = (k < 8);
            ef[5] = (k > 0) && (k % 2 == 1);
            ef[3] = (k > 0) && (k % 2 == 0);
            ea = (k >= 8) ? 16'h0 :
                 (k % 2 == 0) ? 16'h0100 + 16'(k) : 16'h0200 + 16'(k);
            checks++;
            if (f1 !== ef || memAddr1 !== ea) begin
                errors++;
                $display("FAIL lat1_t%0d flags=%b addr=%h need %b %h", k, f1, memAddr1, ef, ea);
            end
            checks++;
            if ((ef[5] && ifData1 !== memRdData) ||
                (ef[3] && dRdData1 !== memRdData)) begin
                errors++;
                $display("FAIL lat1_data_t%0d if=%h d=%h need %h", k, ifData1, dRdData1, memRdData);
            end
        end
    endtask

    // Model: an access issued at cycle iss completes at iss+lat; an
    // issue slot is any cycle with nothing in flight or a completion.
    task automatic test_random(input bit which, input int lat, input int ncyc);
        bit            infl = 0, own_d = 0, own_we = 0;
        int            iss = 0, starve = 0;
        bit            ifP = 0, ifO = 0, dP = 0, dO = 0, dw = 0;
        bit            comp, slot, win_d, win_if;
        logic [AW-1:0] ia = '0, da = '0, ea;
        logic [DW-1:0] wd = '0, rd, ewd, eif, ed;
        logic [6:0]    ef;
        sel = which;
        do_reset();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            comp = infl && (cyc - iss == lat);
            if (comp) begin
                if (own_d) dO = 0;
                else ifO = 0;
            end
            if (!ifP && !ifO && $urandom_range(0, 1) == 1) begin
                ifP = 1;
                ia  = AW'($urandom);
            end
            if (!dP && !dO && $urandom_range(0, 1) == 1) begin
                dP = 1;
                da = AW'($urandom);
                dw = 1'($urandom_range(0, 1));
                wd = $urandom;
            end
            rd        = $urandom;
            ifReq     = ifP;
            ifAddr    = ia;
            dReq      = dP;
            dWe       = dw;
            dAddr     = da;
            dWrData   = wd;
            memRdData = rd;
            slot   = !infl || comp;
            win_d  = slot && dP && (!ifP || starve < LIM);
            win_if = slot && ifP && !win_d;
            ef  = {win_if, comp && !own_d, win_d, comp && own_d,
                   win_if || win_d, win_d && dw,
                   (ifP && !win_if) || (dP && !win_d) || (infl && !comp)};
            ea  = win_d ? da : (win_if ? ia : '0);
            ewd = (win_d && dw) ? wd : '0;
            eif = (comp && !own_d) ? rd : '0;
            ed  = (comp && own_d && !own_we) ? rd : '0;
            #1;
            checks++;
            if (sf !== ef) begin
                errors++;
                $display("FAIL rand%0d_flags cyc=%0d got=%b need=%b", lat, cyc, sf, ef);
            end
            checks++;
            if (s_memAddr !== ea || s_memWrData !== ewd) begin
                errors++;
                $display("FAIL rand%0d_mem cyc=%0d addr=%h wd=%h need %h %h",
                         lat, cyc, s_memAddr, s_memWrData, ea, ewd);
            end
            checks++;
            if (s_ifData !== eif || s_dRdData !== ed) begin
                errors++;
                $display("FAIL rand%0d_rdata cyc=%0d if=%h d=%h need %h %h",
                         lat, cyc, s_ifData, s_dRdData, eif, ed);
            end
            if (win_d) begin
                infl = 1; iss = cyc; own_d = 1; own_we = dw;
                dP = 0; dO = 1;
                if (ifP && starve < LIM) starve++;
            end else if (win_if) begin
                infl = 1; iss = cyc; own_d = 0; own_we = 0;
                ifP = 0; ifO = 1;
                starve = 0;
            end else if (slot) begin
                infl = 0;
            end
        end
        idle_inputs();
        sel = 1'b0;
    endtask

    initial begin
        sel = 1'b0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_if_fetch();
        test_both();
        test_starve();
        test_store();
        test_reset_mid();
        test_lat1();
        test_random(1'b0, 2, 600);
        test_random(1'b1, 1, 600);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
